// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and constants for the UART command frame parser and the control logic.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        S_SYNC    = 3'd0,
        S_CMD     = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CSUM    = 3'd4,
        S_RESP    = 3'd5,
        S_WAIT_TX = 3'd6
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam logic [7:0] ACK_DEFAULT  = 8'h06;
    localparam logic [7:0] NAK_DEFAULT  = 8'h15;

    // Command codes understood by the robot control logic.
    localparam logic [7:0] CMD_NOP      = 8'h00;
    localparam logic [7:0] CMD_MOVE     = 8'h10;
    localparam logic [7:0] CMD_STOP     = 8'h20;
    localparam logic [7:0] CMD_SET_SPD  = 8'h30;
    localparam logic [7:0] CMD_QUERY    = 8'h40;

    // Return word with byte lane 'lane' replaced by b (lane 0 is bits [7:0]).
    function automatic logic [31:0] put_lane(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  b);
        logic [31:0] w;
        w = word;
        case (lane)
            2'd0:    w[7:0]   = b;
            2'd1:    w[15:8]  = b;
            2'd2:    w[23:16] = b;
            default: w[31:24] = b;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Bundle of UART-side and control-side signals of the command parser.
// Latency: none (wiring only).
// Backpressure: transmitter busy/done pace the response byte; receive side has none.
interface uart_cmd_parser_if;
    logic        i_RX_DV;
    logic [7:0]  i_RX_Byte;
    logic        i_Tx_Active;
    logic        i_Tx_Done;
    logic        o_Tx_DV;
    logic [7:0]  o_Tx_Byte;
    logic        o_Cmd_Valid;
    logic [7:0]  o_Cmd;
    logic [2:0]  o_Len;
    logic [31:0] o_Payload;
    logic        o_Err_Checksum;
    logic        o_Err_Length;
    logic        o_Err_Timeout;
    logic        o_Busy;

    // Environment side: drives the receiver/transmitter status, observes results.
    modport master (
        output i_RX_DV, i_RX_Byte, i_Tx_Active, i_Tx_Done,
        input  o_Tx_DV, o_Tx_Byte, o_Cmd_Valid, o_Cmd, o_Len, o_Payload,
               o_Err_Checksum, o_Err_Length, o_Err_Timeout, o_Busy
    );

    // Parser side.
    modport slave (
        input  i_RX_DV, i_RX_Byte, i_Tx_Active, i_Tx_Done,
        output o_Tx_DV, o_Tx_Byte, o_Cmd_Valid, o_Cmd, o_Len, o_Payload,
               o_Err_Checksum, o_Err_Length, o_Err_Timeout, o_Busy
    );
endinterface

// File: rtl/uart_cmd_parser_rx_byte_strobe.sv
// Turns a level receiver-valid into exactly one registered event per received byte.
// Latency: event and captured byte appear 1 cycle after rx_dv rises.
// Backpressure: none; a byte is taken on every rising edge of rx_dv.
module rx_byte_strobe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_dv,
    input  logic [7:0] rx_dat,
    output logic       evt,
    output logic [7:0] evt_dat
);

    logic dv_q;

    // Remember last DV level and register its rising edge together with the byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q    <= 1'b0;
            evt     <= 1'b0;
            evt_dat <= 8'h00;
        end else begin
            dv_q <= rx_dv;
            evt  <= rx_dv & ~dv_q;
            if (rx_dv & ~dv_q) begin
                evt_dat <= rx_dat;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles SYNC/CMD/LEN/payload/CSUM frames into command strobes and answers ACK or NAK.
// Latency: strobe/errors 1 cycle after the closing byte event; response byte same cycle if tx idle.
// Backpressure: response waits for tx idle; bytes arriving while responding are dropped.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE    = SYNC_DEFAULT,
    parameter int          MAX_LEN      = 4,
    parameter logic [15:0] TIMEOUT_CLKS = 16'd50000,
    parameter logic [7:0]  ACK_BYTE     = ACK_DEFAULT,
    parameter logic [7:0]  NAK_BYTE     = NAK_DEFAULT
) (
    input  logic               i_Clock,
    input  logic               i_Reset_n,
    uart_cmd_parser_if.slave   bus
);

    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [15:0] TMO_LAST  = TIMEOUT_CLKS - 16'd1;

    state_t      state;
    state_t      resp_state;
    logic        evt;
    logic [7:0]  evt_dat;
    logic [7:0]  cmd_q;
    logic [7:0]  xor_q;
    logic [2:0]  len_q;
    logic [2:0]  idx_q;
    logic [31:0] pay_q;
    logic [15:0] tmo_cnt;
    logic        timed;
    logic        tmo_hit;

    logic        tx_dv_q;
    logic [7:0]  tx_byte_q;
    logic        valid_q;
    logic [7:0]  cmd_out_q;
    logic [2:0]  len_out_q;
    logic [31:0] pay_out_q;
    logic        err_cs_q;
    logic        err_len_q;
    logic        err_tmo_q;

    rx_byte_strobe u_strobe (
        .clk     (i_Clock),
        .rst_n   (i_Reset_n),
        .rx_dv   (bus.i_RX_DV),
        .rx_dat  (bus.i_RX_Byte),
        .evt     (evt),
        .evt_dat (evt_dat)
    );

    // Only the mid-frame states are subject to the inter-byte idle limit;
    // a byte arriving in the expiry cycle takes precedence over the timeout.
    assign timed   = state inside {S_CMD, S_LEN, S_PAYLOAD, S_CSUM};
    assign tmo_hit = timed && !evt && (tmo_cnt == TMO_LAST);

    // A response is sent immediately when the transmitter is free, otherwise parked in S_RESP.
    assign resp_state = bus.i_Tx_Active ? S_RESP : S_WAIT_TX;

    // Frame parser, idle timer and all registered outputs.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state     <= S_SYNC;
            cmd_q     <= 8'h00;
            xor_q     <= 8'h00;
            len_q     <= 3'd0;
            idx_q     <= 3'd0;
            pay_q     <= 32'h0;
            tmo_cnt   <= 16'd0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            valid_q   <= 1'b0;
            cmd_out_q <= 8'h00;
            len_out_q <= 3'd0;
            pay_out_q <= 32'h0;
            err_cs_q  <= 1'b0;
            err_len_q <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            tx_dv_q   <= 1'b0;
            valid_q   <= 1'b0;
            err_cs_q  <= 1'b0;
            err_len_q <= 1'b0;
            err_tmo_q <= 1'b0;

            if (evt || !timed) begin
                tmo_cnt <= 16'd0;
            end else begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end

            if (tmo_hit) begin
                err_tmo_q <= 1'b1;
                state     <= S_SYNC;
            end else begin
                case (state)
                    S_SYNC: begin
                        if (evt && evt_dat == SYNC_BYTE) begin
                            state <= S_CMD;
                        end
                    end
                    S_CMD: begin
                        if (evt) begin
                            cmd_q <= evt_dat;
                            xor_q <= evt_dat;
                            pay_q <= 32'h0;
                            idx_q <= 3'd0;
                            state <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (evt) begin
                            xor_q <= xor_q ^ evt_dat;
                            if (evt_dat > MAX_LEN_B) begin
                                err_len_q <= 1'b1;
                                tx_byte_q <= NAK_BYTE;
                                tx_dv_q   <= !bus.i_Tx_Active;
                                state     <= resp_state;
                            end else begin
                                len_q <= evt_dat[2:0];
                                state <= (evt_dat == 8'h00) ? S_CSUM : S_PAYLOAD;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (evt) begin
                            pay_q <= put_lane(pay_q, idx_q[1:0], evt_dat);
                            xor_q <= xor_q ^ evt_dat;
                            idx_q <= idx_q + 3'd1;
                            if (idx_q + 3'd1 == len_q) begin
                                state <= S_CSUM;
                            end
                        end
                    end
                    S_CSUM: begin
                        if (evt) begin
                            tx_dv_q <= !bus.i_Tx_Active;
                            state   <= resp_state;
                            if (evt_dat == xor_q) begin
                                cmd_out_q <= cmd_q;
                                len_out_q <= len_q;
                                pay_out_q <= pay_q;
                                valid_q   <= 1'b1;
                                tx_byte_q <= ACK_BYTE;
                            end else begin
                                err_cs_q  <= 1'b1;
                                tx_byte_q <= NAK_BYTE;
                            end
                        end
                    end
                    S_RESP: begin
                        if (!bus.i_Tx_Active) begin
                            tx_dv_q <= 1'b1;
                            state   <= S_WAIT_TX;
                        end
                    end
                    S_WAIT_TX: begin
                        if (bus.i_Tx_Done) begin
                            state <= S_SYNC;
                        end
                    end
                    default: state <= S_SYNC;
                endcase
            end
        end
    end

    assign bus.o_Tx_DV        = tx_dv_q;
    assign bus.o_Tx_Byte      = tx_byte_q;
    assign bus.o_Cmd_Valid    = valid_q;
    assign bus.o_Cmd          = cmd_out_q;
    assign bus.o_Len          = len_out_q;
    assign bus.o_Payload      = pay_out_q;
    assign bus.o_Err_Checksum = err_cs_q;
    assign bus.o_Err_Length   = err_len_q;
    assign bus.o_Err_Timeout  = err_tmo_q;
    assign bus.o_Busy         = (state != S_SYNC);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed frames plus random frames
// judged by a frame-level model (checksum/length rules applied to byte lists).
// A small transmitter model answers every response byte with busy then done.
`timescale 1ns/1ps
module tb_uart_cmd_parser;

    localparam logic [15:0] TMO  = 16'd300;
    localparam int          MAXL = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_cmd_parser_if bus ();

    logic tx_busy_m   = 1'b0;
    logic ext_busy    = 1'b0;
    logic tx_inflight = 1'b0;
    assign bus.i_Tx_Active = tx_busy_m | ext_busy;

    uart_cmd_parser #(
        .SYNC_BYTE    (8'hA5),
        .MAX_LEN      (MAXL),
        .TIMEOUT_CLKS (TMO),
        .ACK_BYTE     (8'h06),
        .NAK_BYTE     (8'h15)
    ) dut (
        .i_Clock   (clk),
        .i_Reset_n (rst_n),
        .bus       (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed events.
    logic [7:0] tx_log[$];
    int n_valid = 0, n_cs = 0, n_len = 0, n_tmo = 0;
    int valid_cyc = 0, tx_cyc = 0, len_cyc = 0, tmo_cyc = 0;

    always @(negedge clk) begin
        if (bus.o_Cmd_Valid === 1'b1)    begin n_valid++; valid_cyc = cyc; end
        if (bus.o_Tx_DV === 1'b1)        begin tx_log.push_back(bus.o_Tx_Byte); tx_cyc = cyc; end
        if (bus.o_Err_Checksum === 1'b1) n_cs++;
        if (bus.o_Err_Length === 1'b1)   begin n_len++; len_cyc = cyc; end
        if (bus.o_Err_Timeout === 1'b1)  begin n_tmo++; tmo_cyc = cyc; end
    end

    // Transmitter model: busy for a few cycles after a request, then done for two cycles.
    initial begin
        bus.i_Tx_Done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_Tx_DV === 1'b1) begin
                tx_inflight = 1'b1;
                @(posedge clk); #1 tx_busy_m = 1'b1;
                repeat (4) @(posedge clk);
                #1 tx_busy_m = 1'b0; bus.i_Tx_Done = 1'b1;
                repeat (2) @(posedge clk);
                #1 bus.i_Tx_Done = 1'b0; tx_inflight = 1'b0;
            end
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    int last_rise = 0;

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        @(posedge clk); #1;
        bus.i_RX_DV   = 1'b1;
        bus.i_RX_Byte = b;
        last_rise     = cyc;
        repeat (hold) @(posedge clk);
        #1 bus.i_RX_DV = 1'b0;
        repeat (gap - 1) @(posedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.o_Busy === 1'b0 && !tx_inflight) break;
        end
        check(tag, 64'(k < 300), 64'(1));
    endtask

    // Reference state: last accepted command as the control logic should see it.
    logic [7:0]  m_cmd = 8'h00;
    logic [2:0]  m_len = 3'd0;
    logic [31:0] m_pay = 32'h0;
    logic [7:0]  fr[$];

    task automatic check_outputs(input string tag);
        check({tag, "_cmd"}, 64'(bus.o_Cmd), 64'(m_cmd));
        check({tag, "_len"}, 64'(bus.o_Len), 64'(m_len));
        check({tag, "_pay"}, 64'(bus.o_Payload), 64'(m_pay));
    endtask

    // Send fr[] and judge the outcome from the frame rules alone.
    task automatic run_frame(input int hold_cfg);
        int nv, nt, ncs, nl, k, ln, len_rise;
        logic [7:0]  x;
        logic [31:0] pay;
        bit good, bad_len;
        nv = n_valid; nt = tx_log.size(); ncs = n_cs; nl = n_len;
        ln = int'(fr[2]);
        bad_len = (ln > MAXL);
        good = 1'b0;
        pay = 32'h0;
        if (!bad_len) begin
            x = fr[1] ^ fr[2];
            for (int i = 0; i < ln; i++) begin
                x   = x ^ fr[3 + i];
                pay = pay | (32'(fr[3 + i]) << (8 * i));
            end
            good = (x == fr[fr.size() - 1]);
        end
        len_rise = 0;
        for (int i = 0; i < fr.size(); i++) begin
            send_byte(fr[i], (hold_cfg == 0) ? int'($urandom_range(1, 4)) : hold_cfg,
                      int'($urandom_range(1, 3)));
            if (i == 2) len_rise = last_rise;
        end
        for (k = 0; k < 100 && tx_log.size() == nt; k++) @(negedge clk);
        check("resp_seen", 64'(tx_log.size()), 64'(nt + 1));
        wait_idle("resp_idle");
        if (good) begin
            m_cmd = fr[1];
            m_len = fr[2][2:0];
            m_pay = pay;
        end
        if (tx_log.size() > nt) check("tx_byte", 64'(tx_log[nt]), good ? 64'h06 : 64'h15);
        check("tx_latency", 64'(tx_cyc - last_rise), 64'(2));
        check("valid_cnt", 64'(n_valid - nv), 64'(good));
        check("cs_err_cnt", 64'(n_cs - ncs), 64'(!bad_len && !good));
        check("len_err_cnt", 64'(n_len - nl), 64'(bad_len));
        if (good) check("valid_latency", 64'(valid_cyc - last_rise), 64'(2));
        if (bad_len) check("len_err_latency", 64'(len_cyc - len_rise), 64'(2));
        check_outputs("frame");
    endtask

    initial begin
        int k, nt, nv, nto, rel, nj, mode, ln;
        logic [7:0] jb, cmd, x, p;

        bus.i_RX_DV   = 1'b0;
        bus.i_RX_Byte = 8'h00;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(bus.o_Cmd_Valid), 64'(0));
        check("rst_txdv", 64'(bus.o_Tx_DV), 64'(0));
        check("rst_txbyte", 64'(bus.o_Tx_Byte), 64'(0));
        check("rst_busy", 64'(bus.o_Busy), 64'(0));
        check("rst_errs", 64'({bus.o_Err_Checksum, bus.o_Err_Length, bus.o_Err_Timeout}), 64'(0));
        check_outputs("rst");
        @(posedge clk); #1 rst_n = 1'b1;

        // Two-byte payload with DV held for several cycles per byte.
        fr = {8'hA5, 8'h10, 8'h02, 8'h34, 8'h12, 8'h34};
        run_frame(4);
        check("t1_pay_const", 64'(bus.o_Payload), 64'h0000_1234);

        // Zero-length command, then the same with a corrupted checksum.
        fr = {8'hA5, 8'h20, 8'h00, 8'h20};
        run_frame(0);
        fr = {8'hA5, 8'h20, 8'h00, 8'hFF};
        run_frame(0);
        check("t2_cmd_kept", 64'(bus.o_Cmd), 64'h20);

        // Oversized length: NAK, then trailing bytes must be ignored from the sync hunt.
        fr = {8'hA5, 8'h30, 8'h05};
        run_frame(0);
        nt = tx_log.size(); nv = n_valid;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1, 2);
        repeat (5) @(negedge clk);
        check("t3_trail_no_tx", 64'(tx_log.size()), 64'(nt));
        check("t3_trail_no_valid", 64'(n_valid - nv), 64'(0));
        check("t3_trail_busy", 64'(bus.o_Busy), 64'(0));

        // Mid-frame idle timeout: no response, back to hunting for sync.
        nt = tx_log.size(); nto = n_tmo;
        send_byte(8'hA5, 2, 1); send_byte(8'h40, 2, 1); send_byte(8'h01, 2, 1);
        rel = last_rise;
        for (k = 0; k < 2 * int'(TMO) && n_tmo == nto; k++) @(negedge clk);
        check("t4_tmo_pulse", 64'(n_tmo - nto), 64'(1));
        check("t4_tmo_delay", 64'((tmo_cyc - rel >= int'(TMO) + 1) && (tmo_cyc - rel <= int'(TMO) + 3)), 64'(1));
        @(negedge clk);
        check("t4_busy", 64'(bus.o_Busy), 64'(0));
        check("t4_no_tx", 64'(tx_log.size()), 64'(nt));
        fr = {8'hA5, 8'h40, 8'h01, 8'h5A, 8'h1B};
        run_frame(0);

        // Transmitter busy across the checksum byte: response waits, extra bytes dropped.
        ext_busy = 1'b1;
        nt = tx_log.size(); nv = n_valid; nto = n_tmo;
        fr = {8'hA5, 8'h50, 8'h01, 8'h77, 8'h26};
        for (int i = 0; i < fr.size(); i++) send_byte(fr[i], 2, 1);
        repeat (10) @(negedge clk);
        check("t5_valid", 64'(n_valid - nv), 64'(1));
        check("t5_tx_held", 64'(tx_log.size()), 64'(nt));
        check("t5_busy", 64'(bus.o_Busy), 64'(1));
        send_byte(8'hA5, 1, 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 ext_busy = 1'b0; rel = cyc;
        for (k = 0; k < 20 && tx_log.size() == nt; k++) @(negedge clk);
        check("t5_tx_seen", 64'(tx_log.size()), 64'(nt + 1));
        check("t5_tx_delay", 64'(tx_cyc - rel), 64'(1));
        if (tx_log.size() > nt) check("t5_tx_byte", 64'(tx_log[nt]), 64'h06);
        send_byte(8'hA5, 1, 1);
        wait_idle("t5_idle");
        m_cmd = 8'h50; m_len = 3'd1; m_pay = 32'h0000_0077;
        check_outputs("t5");
        check("t5_no_tmo", 64'(n_tmo - nto), 64'(0));
        fr = {8'hA5, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h10 ^ 8'h03 ^ 8'h01 ^ 8'h02 ^ 8'h03};
        run_frame(0);

        // Reset in the middle of a payload.
        nv = n_valid; nt = tx_log.size();
        send_byte(8'hA5, 1, 1); send_byte(8'h70, 1, 1); send_byte(8'h03, 1, 1);
        send_byte(8'h01, 1, 1); send_byte(8'h02, 1, 1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        m_cmd = 8'h00; m_len = 3'd0; m_pay = 32'h0;
        check_outputs("t6_rst");
        check("t6_busy", 64'(bus.o_Busy), 64'(0));
        check("t6_txbyte", 64'(bus.o_Tx_Byte), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_no_valid", 64'(n_valid - nv), 64'(0));
        check("t6_no_tx", 64'(tx_log.size()), 64'(nt));
        fr = {8'hA5, 8'h70, 8'h01, 8'hA5, 8'h70 ^ 8'h01 ^ 8'hA5};
        run_frame(0);

        // Random frames with leading junk.
        for (int f = 0; f < 30; f++) begin
            nj = $urandom_range(0, 2);
            for (int j = 0; j < nj; j++) begin
                jb = 8'($urandom_range(0, 255));
                if (jb == 8'hA5) jb = 8'h5A;
                send_byte(jb, 1, 1);
            end
            cmd  = 8'($urandom_range(0, 255));
            mode = $urandom_range(0, 9);
            ln   = (mode == 0) ? int'($urandom_range(5, 255)) : int'($urandom_range(0, MAXL));
            fr = {8'hA5, cmd, 8'(ln)};
            if (mode != 0) begin
                x = cmd ^ 8'(ln);
                for (int i = 0; i < ln; i++) begin
                    p = 8'($urandom_range(0, 255));
                    fr.push_back(p);
                    x = x ^ p;
                end
                if (mode <= 2) x = x ^ 8'($urandom_range(1, 255));
                fr.push_back(x);
            end
            run_frame(0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
